a2d_scan_ctrl: RTL and testbench

A2D_SCAN_CTRL -- requirements
Module: a2d_scan_ctrl

---
 rtl/a2d_scan_pkg.sv | 47 ++++
 rtl/a2d_spi_if.sv | 24 ++
 rtl/a2d_res_file.sv | 30 +++
 rtl/a2d_scan_ctrl.sv | 130 +++++++++++++
 tb/tb_a2d_scan_ctrl.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/a2d_scan_pkg.sv
// a2d_scan_pkg: shared types and constants for the A2D scan controller.
// The optional transaction timeout is enabled by defining A2D_TIMEOUT_EN.
package a2d_scan_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SEL,
      TX1,
      W1,
      GAP,
      TX2,
      W2,
      STORE
   } state_t;

   // Upper two bits of every command word sent to the ADC
   localparam logic [1:0] CMD_PREFIX = 2'b00;

   // Width of one stored conversion result
   localparam int RES_W = 12;

   // Clocks spent in W1/W2 without done before the transaction is abandoned
   localparam int TIMEOUT_LIM = 1023;
   localparam int TO_W        = $clog2(TIMEOUT_LIM + 1);

   // done is not trusted in the wrt clock nor in the two clocks that follow it
   localparam int IGN_CLKS = 2;

   typedef struct packed {
      logic       vld;
      logic [2:0] idx;
   } pick_t;

   // Lowest-index set bit of a channel mask
   function automatic pick_t first_set(input logic [7:0] mask);
      pick_t p;
      p = '0;
      for (int i = 7; i >= 0; i--) begin
         if (mask[i]) begin
            p.vld = 1'b1;
            p.idx = 3'(i);
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/a2d_spi_if.sv
// a2d_spi_if: handshake between the scan controller and the 16-bit SPI master.
// master = scan controller, slave = SPI master block.
interface a2d_spi_if;

   logic        wrt;
   logic [15:0] cmd;
   logic        done;
   logic [15:0] rd_data;

   modport master (
      output wrt,
      output cmd,
      input  done,
      input  rd_data
   );

   modport slave (
      input  wrt,
      input  cmd,
      output done,
      output rd_data
   );

endinterface

// File: rtl/a2d_res_file.sv
// a2d_res_file: 8 x RES_W result registers, one synchronous write port,
// one asynchronous read port (read returns the pre-write value in a write clock).
module a2d_res_file
   import a2d_scan_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic [2:0]       waddr,
   input  logic [RES_W-1:0] wdata,
   input  logic [2:0]       raddr,
   output logic [RES_W-1:0] rdata
);

   logic [RES_W-1:0] mem [8];

   // Result storage: cleared by reset, written only when we is high
   // NOTE: this array is small and must read 0 during reset, so it is built
   // from flops with an async clear rather than an inferred RAM (RAMs cannot reset).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) mem[i] <= '0;
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/a2d_scan_ctrl.sv
// a2d_scan_ctrl: scans the enabled ADC channels in ascending order, running two
// SPI transactions per channel and storing the 12-bit result of the second.
// Optional: define A2D_TIMEOUT_EN to abandon a scan when done never arrives.
module a2d_scan_ctrl
   import a2d_scan_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             strt_scan,
   input  logic [7:0]       chnl_mask,
   input  logic [2:0]       rd_chnl,
   output logic [RES_W-1:0] rd_res,
   output logic             busy,
   output logic             scan_done,
   output logic             err,
   a2d_spi_if.master        spi
);

   state_t           state;
   logic [7:0]       mask_q;     // channels still to visit in this scan
   logic [2:0]       chnl;       // channel being converted
   logic [1:0]       ign_cnt;    // clocks left in which done is ignored
   logic [RES_W-1:0] res_q;      // rd_data captured at transaction completion
   pick_t            pick;
   logic             unused_rd_bits;

   assign pick           = first_set(mask_q);
   assign unused_rd_bits = &spi.rd_data[15:RES_W];

`ifdef A2D_TIMEOUT_EN
   logic [TO_W-1:0] to_cnt;
`else
   // Without the timeout option the scan waits for done forever
   assign err = 1'b0;
`endif

   // Scan sequencer with registered outputs
   // NOTE: every state register here uses <= so all of them update together
   // from pre-edge values; a blocking = would leak new values into later lines.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         mask_q    <= '0;
         chnl      <= '0;
         ign_cnt   <= '0;
         res_q     <= '0;
         busy      <= 1'b0;
         scan_done <= 1'b0;
         spi.wrt   <= 1'b0;
         spi.cmd   <= '0;
`ifdef A2D_TIMEOUT_EN
         err       <= 1'b0;
         to_cnt    <= '0;
`endif
      end else begin
         spi.wrt   <= 1'b0;
         scan_done <= 1'b0;
         case (state)
            IDLE: begin
               if (strt_scan) begin
                  mask_q <= chnl_mask;
                  busy   <= 1'b1;
                  state  <= SEL;
`ifdef A2D_TIMEOUT_EN
                  err    <= 1'b0;
`endif
               end
            end
            SEL: begin
               if (pick.vld) begin
                  chnl             <= pick.idx;
                  mask_q[pick.idx] <= 1'b0;
                  spi.cmd          <= {CMD_PREFIX, pick.idx, 11'h000};
                  spi.wrt          <= 1'b1;
                  state            <= TX1;
               end else begin
                  busy      <= 1'b0;
                  scan_done <= 1'b1;
                  state     <= IDLE;
               end
            end
            TX1, TX2: begin
               // wrt is high during this clock; arm the done-ignore window
               ign_cnt <= 2'(IGN_CLKS);
`ifdef A2D_TIMEOUT_EN
               to_cnt  <= '0;
`endif
               state   <= (state == TX1) ? W1 : W2;
            end
            W1, W2: begin
               if (ign_cnt != '0) ign_cnt <= ign_cnt - 2'd1;
               if (ign_cnt == '0 && spi.done) begin
                  res_q <= spi.rd_data[RES_W-1:0];
                  state <= (state == W1) ? GAP : STORE;
               end
`ifdef A2D_TIMEOUT_EN
               else if (to_cnt == TO_W'(TIMEOUT_LIM - 1)) begin
                  err       <= 1'b1;
                  busy      <= 1'b0;
                  scan_done <= 1'b1;
                  state     <= IDLE;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
`endif
            end
            GAP: begin
               // One idle clock after completion, then the second wrt
               spi.wrt <= 1'b1;
               state   <= TX2;
            end
            STORE: begin
               state <= SEL;
            end
            default: state <= IDLE;
         endcase
      end
   end

   a2d_res_file u_res_file (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (state == STORE),
      .waddr (chnl),
      .wdata (res_q),
      .raddr (rd_chnl),
      .rdata (rd_res)
   );

endmodule

// File: tb/tb_a2d_scan_ctrl.sv
// tb_a2d_scan_ctrl: directed bench for a2d_scan_ctrl with an SPI master model
// and a command scoreboard. Build with A2D_TIMEOUT_EN to exercise the timeout.
module tb_a2d_scan_ctrl;
   import a2d_scan_pkg::*;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             strt_scan = 1'b0;
   logic [7:0]       chnl_mask = '0;
   logic [2:0]       rd_chnl = '0;
   logic [RES_W-1:0] rd_res;
   logic             busy, scan_done, err;

   a2d_spi_if spi ();

   a2d_scan_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .strt_scan (strt_scan),
      .chnl_mask (chnl_mask),
      .rd_chnl   (rd_chnl),
      .rd_res    (rd_res),
      .busy      (busy),
      .scan_done (scan_done),
      .err       (err),
      .spi       (spi)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [15:0] cmd_exp [$];    // expected cmd per wrt, pushed at scan start
   logic [15:0] resp [8];       // transaction-2 reply per channel
   int          wrt_cnt = 0;
   int          sd_cnt  = 0;
   int          txn2_done_cnt = 0;
   bit          stall = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // SPI master model: samples 1ns after each edge, answers 5 clks after wrt
   initial begin
      bit          phase = 1'b0;
      bit          txn_is2 = 1'b0;
      int          lat_cnt = 0;
      logic [2:0]  txn_ch = '0;
      logic [15:0] txn_cmd = '0;
      spi.done    = 1'b1;
      spi.rd_data = '0;
      forever begin
         @(posedge clk);
         #1;
         if (scan_done) sd_cnt++;
         if (!rst_n) begin
            spi.done = 1'b1;
            lat_cnt  = 0;
            phase    = 1'b0;
         end else begin
            if (scan_done) phase = 1'b0;
            if (spi.wrt) begin
               wrt_cnt++;
               check("cmd_expected", 32'(cmd_exp.size() > 0), 32'd1);
               if (cmd_exp.size() > 0) check("cmd", spi.cmd, cmd_exp.pop_front());
               txn_cmd = spi.cmd;
               txn_ch  = spi.cmd[13:11];
               txn_is2 = phase;
               phase   = ~phase;
               lat_cnt = 5;
            end else if (lat_cnt > 0) begin
               spi.done = 1'b0;
               lat_cnt--;
            end else if (!spi.done && !stall) begin
               check("cmd_stable", spi.cmd, txn_cmd);
               spi.rd_data = txn_is2 ? resp[txn_ch] : 16'hFFFF;
               spi.done    = 1'b1;
               if (txn_is2) txn2_done_cnt++;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic read_res(input logic [2:0] ch, input logic [RES_W-1:0] exp, input string tag);
      rd_chnl = ch;
      #1;
      check(tag, rd_res, exp);
   endtask

   task automatic start(input logic [7:0] m, input bit push);
      if (push) begin
         for (int i = 0; i < 8; i++) begin
            if (m[i]) begin
               cmd_exp.push_back({CMD_PREFIX, 3'(i), 11'h000});
               cmd_exp.push_back({CMD_PREFIX, 3'(i), 11'h000});
            end
         end
      end
      chnl_mask = m;
      strt_scan = 1'b1;
      tick();
      strt_scan = 1'b0;
   endtask

   task automatic wait_scan_done(input int budget, input string tag);
      int k = 0;
      while (!scan_done && k < budget) begin
         tick();
         k++;
      end
      check(tag, scan_done, 1'b1);
   endtask

   task automatic wait_wrt(input int w0, input string tag);
      int k = 0;
      while (wrt_cnt == w0 && k < 50) begin
         tick();
         k++;
      end
      check(tag, 32'(wrt_cnt != w0), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w0, s0, t0, k;
      for (int i = 0; i < 8; i++) resp[i] = '0;

      // Reset state
      repeat (3) tick();
      check("rst_busy", busy, 1'b0);
      check("rst_scan_done", scan_done, 1'b0);
      check("rst_wrt", spi.wrt, 1'b0);
      check("rst_err", err, 1'b0);
      check("rst_cmd", spi.cmd, 16'h0000);
      read_res(3'd5, 12'h000, "rst_res5");
      rst_n = 1'b1;
      tick();

      // Mask 05: ch0 then ch2
      resp[0] = 16'h0ABC;
      resp[2] = 16'h0123;
      w0 = wrt_cnt;
      s0 = sd_cnt;
      start(8'h05, 1'b1);
      check("m05_busy", busy, 1'b1);
      wait_scan_done(200, "m05_done_seen");
      tick();
      tick();
      check("m05_wrt_count", wrt_cnt - w0, 4);
      check("m05_done_count", sd_cnt - s0, 1);
      check("m05_cmd_left", cmd_exp.size(), 0);
      check("m05_busy_end", busy, 1'b0);
      read_res(3'd0, 12'hABC, "m05_res0");
      read_res(3'd2, 12'h123, "m05_res2");
      read_res(3'd1, 12'h000, "m05_res1");

      // Mask 00: scan_done in the 2nd clk after strt_scan, no wrt
      w0 = wrt_cnt;
      s0 = sd_cnt;
      start(8'h00, 1'b1);
      check("m00_done_early", scan_done, 1'b0);
      check("m00_busy", busy, 1'b1);
      tick();
      check("m00_done", scan_done, 1'b1);
      tick();
      tick();
      check("m00_busy_end", busy, 1'b0);
      check("m00_wrt_count", wrt_cnt - w0, 0);
      check("m00_done_count", sd_cnt - s0, 1);

      // Second strt_scan mid-scan is ignored
      resp[0] = 16'h0777;
      w0 = wrt_cnt;
      s0 = sd_cnt;
      start(8'h01, 1'b1);
      repeat (3) tick();
      start(8'hFF, 1'b0);
      wait_scan_done(200, "ign_done_seen");
      tick();
      tick();
      check("ign_wrt_count", wrt_cnt - w0, 2);
      check("ign_done_count", sd_cnt - s0, 1);
      check("ign_cmd_left", cmd_exp.size(), 0);
      read_res(3'd0, 12'h777, "ign_res0");
      read_res(3'd1, 12'h000, "ign_res1");

      // Back-to-back scans of ch7: old value in STORE clk, new value after
      resp[7] = 16'h0111;
      start(8'h80, 1'b1);
      wait_scan_done(200, "b2b_first_done");
      resp[7] = 16'h0222;
      rd_chnl = 3'd7;
      t0 = txn2_done_cnt;
      start(8'h80, 1'b1);
      k = 0;
      while (txn2_done_cnt == t0 && k < 200) begin
         tick();
         k++;
      end
      check("b2b_txn2_seen", 32'(txn2_done_cnt != t0), 32'd1);
      tick();
      read_res(3'd7, 12'h111, "b2b_store_old");
      tick();
      read_res(3'd7, 12'h222, "b2b_after_new");
      wait_scan_done(20, "b2b_second_done");
      tick();

      // Reset during W1 after ch3 stored 555
      resp[3] = 16'h0555;
      start(8'h08, 1'b1);
      wait_scan_done(200, "rstw1_prior_done");
      tick();
      read_res(3'd3, 12'h555, "rstw1_prior_res3");
      stall = 1'b1;
      w0 = wrt_cnt;
      start(8'h08, 1'b1);
      wait_wrt(w0, "rstw1_wrt_seen");
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      check("rstw1_busy", busy, 1'b0);
      check("rstw1_wrt", spi.wrt, 1'b0);
      check("rstw1_cmd", spi.cmd, 16'h0000);
      read_res(3'd3, 12'h000, "rstw1_res3");
      cmd_exp.delete();
      stall = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();

      // done held low for 1100 clks after wrt
      resp[1] = 16'h0456;
      stall = 1'b1;
      w0 = wrt_cnt;
      s0 = sd_cnt;
      start(8'h02, 1'b1);
      wait_wrt(w0, "stall_wrt_seen");
      repeat (1000) tick();
      check("stall_err_1000", err, 1'b0);
      check("stall_busy_1000", busy, 1'b1);
      repeat (100) tick();
`ifdef A2D_TIMEOUT_EN
      check("to_err", err, 1'b1);
      check("to_busy", busy, 1'b0);
      check("to_done_count", sd_cnt - s0, 1);
      cmd_exp.delete();
      stall = 1'b0;
      tick();
      start(8'h00, 1'b0);
      check("to_err_cleared", err, 1'b0);
      wait_scan_done(20, "to_next_done");
`else
      check("noto_err", err, 1'b0);
      check("noto_busy", busy, 1'b1);
      check("noto_done_count", sd_cnt - s0, 0);
      stall = 1'b0;
      wait_scan_done(200, "noto_done_seen");
      tick();
      read_res(3'd1, 12'h456, "noto_res1");
      check("noto_err_end", err, 1'b0);
`endif
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
